keypad_entry: RTL

//  Consumes the 16-bit key-level vector from the 4x4 keypad scanner (bit i = row*4+col).

---
 rtl/keypad_entry.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad press qualifier, BCD entry buffer and code handshake
// Optional IDLE_CLEAR_EN: clear a partial entry after TIMEOUT_CYC idle cycles.
module keypad_entry #(
  parameter int DIGITS      = 4,
  parameter int STABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                         clkms,
  input  logic                         rst,
  input  logic [15:0]                  num,
  input  logic                         code_ready,
  output logic                         code_valid,
  output logic [4*DIGITS-1:0]          code_out,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         key_evt,
  output logic [3:0]                   key_code,
  output logic                         err
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int SW = $clog2(STABLE_CYC+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] cnt, cnt_nx;
  logic [15:0]   pat, pat_nx;
  logic          armed;
  logic          onehot, fire, full;
  logic [3:0]    key_idx, key_map;
  logic [BW-1:0] entry;
  logic          act_clear, act_shift, act_back, act_submit, act_err;

  assign onehot = (num != 16'h0) && ((num & (num - 16'd1)) == 16'h0);
  assign full   = (digit_cnt == CW'(DIGITS));

  // armed stays low after reset until the keypad has been seen idle once,
  // so a key held through reset is not reported as a new press
  always_ff @(posedge clkms) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pat   <= pat_nx;
      armed <= armed | (num == 16'h0);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pat_nx   = pat;
    case (state)
      IDLE: if (armed && onehot) begin
        pat_nx   = num;
        cnt_nx   = SW'(1);
        state_nx = (STABLE_CYC <= 1) ? HELD : PRESS;
      end
      PRESS: if (num == pat) begin
        cnt_nx = cnt + 1'b1;
        if (int'(cnt) + 1 >= STABLE_CYC) state_nx = HELD;
      end else begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      HELD: if (num == 16'h0) begin
        cnt_nx   = SW'(1);
        state_nx = (STABLE_CYC <= 1) ? IDLE : RELEASE;
      end
      RELEASE: if (num != 16'h0) begin
        state_nx = HELD;
      end else begin
        cnt_nx = cnt + 1'b1;
        if (int'(cnt) + 1 >= STABLE_CYC) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < 16; i++)
      if (num[i]) key_idx = 4'(i);
  end

  always_comb begin
    case (key_idx)
      4'd0:    key_map = 4'h1;
      4'd1:    key_map = 4'h2;
      4'd2:    key_map = 4'h3;
      4'd3:    key_map = 4'hA;
      4'd4:    key_map = 4'h4;
      4'd5:    key_map = 4'h5;
      4'd6:    key_map = 4'h6;
      4'd7:    key_map = 4'hB;
      4'd8:    key_map = 4'h7;
      4'd9:    key_map = 4'h8;
      4'd10:   key_map = 4'h9;
      4'd11:   key_map = 4'hC;
      4'd12:   key_map = 4'hE;
      4'd13:   key_map = 4'h0;
      4'd14:   key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  end

  always_comb begin
    fire = ((state == IDLE) && armed && onehot && (STABLE_CYC <= 1)) ||
           ((state == PRESS) && (num == pat) && (int'(cnt) + 1 >= STABLE_CYC));
    act_clear  = 1'b0;
    act_shift  = 1'b0;
    act_back   = 1'b0;
    act_submit = 1'b0;
    act_err    = 1'b0;
    if (fire) begin
      if (key_map == 4'hD)       act_clear = 1'b1;
      else if (code_valid)       act_err   = 1'b1;
      else if (key_map <= 4'h9) begin
        if (full) act_err = 1'b1; else act_shift = 1'b1;
      end else if (key_map == 4'hE) begin
        if (digit_cnt == '0) act_err = 1'b1; else act_back = 1'b1;
      end else if (key_map == 4'hF) begin
        if (!full) act_err = 1'b1; else act_submit = 1'b1;
      end
    end
  end

`ifdef IDLE_CLEAR_EN
  logic [$clog2(TIMEOUT_CYC+1)-1:0] idle_cnt;
`endif

  always_ff @(posedge clkms) begin
    if (rst) begin
      code_valid <= 1'b0;
      code_out   <= '0;
      digit_cnt  <= '0;
      key_evt    <= 1'b0;
      key_code   <= '0;
      err        <= 1'b0;
      entry      <= '0;
`ifdef IDLE_CLEAR_EN
      idle_cnt   <= '0;
`endif
    end else begin
      key_evt <= fire;
      err     <= act_err;
      if (fire) key_code <= key_map;
      if (code_valid && code_ready) code_valid <= 1'b0;
      if (act_clear) begin
        entry     <= '0;
        digit_cnt <= '0;
      end
      if (act_shift) begin
        entry     <= (entry << 4) | BW'(key_map);
        digit_cnt <= digit_cnt + 1'b1;
      end
      if (act_back) begin
        entry     <= entry >> 4;
        digit_cnt <= digit_cnt - 1'b1;
      end
      if (act_submit) begin
        code_valid <= 1'b1;
        code_out   <= entry;
        entry      <= '0;
        digit_cnt  <= '0;
      end
`ifdef IDLE_CLEAR_EN
      if (fire) begin
        idle_cnt <= '0;
      end else if ((digit_cnt != '0) && !code_valid) begin
        if (int'(idle_cnt) + 1 >= TIMEOUT_CYC) begin
          idle_cnt  <= '0;
          entry     <= '0;
          digit_cnt <= '0;
          err       <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
`endif
    end
  end
endmodule
